// File: rtl/axis_img_pattern_gen.sv
// axis_img_pattern_gen: AXI4-Stream raster test-pattern source with back-pressure and inter-frame blanking
// Ports: clk, resetn (async, active-low), enable (run request), pattern (latched at frame start),
//   m_axis_tdata/tvalid/tready/tuser/tlast (video stream; tuser = SOF, tlast = EOL),
//   frame_done (pulse after last pixel handshake), frame_cnt (completed frames, wraps).
// Optional: define IMG_PATTERN_HBLANK_EN to insert H_BLANK idle cycles between lines.
module axis_img_pattern_gen #(
  parameter int IMG_WIDTH  = 2560,
  parameter int IMG_HEIGHT = 1440,
  parameter int DATA_WIDTH = 8,
  parameter int V_BLANK    = 16,
  parameter int H_BLANK    = 4,
  parameter int CHK_SHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int MAXB = V_BLANK > H_BLANK ? V_BLANK : H_BLANK;
  localparam int BW = MAXB < 1 ? 1 : $clog2(MAXB + 1);
`ifdef IMG_PATTERN_HBLANK_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;
`endif
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bcnt;
  logic [1:0] pat;
  logic hs, x_last, y_last;
  assign hs = m_axis_tvalid & m_axis_tready;
  assign x_last = x == XW'(IMG_WIDTH - 1);
  assign y_last = y == YW'(IMG_HEIGHT - 1);
  assign m_axis_tvalid = state == ACTIVE;
  assign m_axis_tuser = m_axis_tvalid & (x == '0) & (y == '0);
  assign m_axis_tlast = m_axis_tvalid & x_last;
  // x/y are zero-extended so narrow counters and large CHK_SHIFT never index out of range
  assign m_axis_tdata = pat == 2'd0 ? DATA_WIDTH'(32'(x)) :
                        pat == 2'd1 ? DATA_WIDTH'(32'(y)) :
                        pat == 2'd2 ? {DATA_WIDTH{1'(32'(x) >> CHK_SHIFT) ^ 1'(32'(y) >> CHK_SHIFT)}} :
                                      DATA_WIDTH'(32'(x) + 32'(frame_cnt));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      bcnt       <= '0;
      pat        <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= ACTIVE;
          pat   <= pattern;
        end
        ACTIVE: if (hs) begin
          bcnt <= '0;
          if (!x_last) x <= x + 1'b1;
          else begin
            x <= '0;
            if (!y_last) begin
              y <= y + 1'b1;
`ifdef IMG_PATTERN_HBLANK_EN
              if (H_BLANK > 0) state <= HBLANK;
`endif
            end else begin
              y          <= '0;
              frame_cnt  <= frame_cnt + 1'b1;
              frame_done <= 1'b1;
              // with no vertical blanking the run/stop decision is taken right here
              if (V_BLANK > 0) state <= VBLANK;
              else if (enable) pat <= pattern;
              else state <= IDLE;
            end
          end
        end
`ifdef IMG_PATTERN_HBLANK_EN
        HBLANK: begin
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(H_BLANK - 1)) state <= ACTIVE;
        end
`endif
        VBLANK: begin
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(V_BLANK - 1)) begin
            state <= enable ? ACTIVE : IDLE;
            if (enable) pat <= pattern;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
